// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle Moore sequencer for the 16-bit CPU datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the
// datapath control lines and the PC/IR write enables, and stalls in MEM until
// the data memory reports MemReady.
//
// Ports:
//   Clock, Reset        rising-edge clock; asynchronous active-high reset
//   Enable              run permission, sampled only in FETCH
//   opcode[3:0]         instruction[15:12], valid from DECODE onward
//   MemReady            data memory finished the current access
//   IRWrite, PCWrite    instruction-register capture / PC update strobe
//   RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp[1:0]
//                       datapath controls
//   Busy                high whenever the FSM is not in FETCH
//   IllegalOp           one-cycle pulse on an undefined opcode
//   InstrCount[15:0]    retired-instruction count
//
// Build option: define CTRL_PERF_CNT_EN to include the InstrCount counter.
// Without it, InstrCount is tied to zero and no counter flops are built.
module multicycle_control #(
  parameter logic [3:0] RESET_OPCODE = 4'b0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [3:0]  opcode,
  input  logic        MemReady,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        Busy,
  output logic        IllegalOp,
  output logic [15:0] InstrCount
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ANDI  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ORI   = 4'b0011;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'b0100;
  localparam logic [OP_W-1:0] OP_LW    = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW    = 4'b1001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] opcode_q, opcode_d;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_LW, OP_SW: is_legal = 1'b1;
      default:                                                 is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_itype(input logic [OP_W-1:0] op);
    is_itype = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // State and opcode latch
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= FETCH;
      opcode_q <= RESET_OPCODE;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next state and Moore control decode
  always_comb begin
    state_d   = state_q;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALU_ADD;
    IllegalOp = 1'b0;
    Busy      = (state_q != FETCH);
    // The opcode input is valid in DECODE; the latch feeds EXEC and later.
    opcode_d  = (state_q == DECODE) ? opcode : opcode_q;

    case (state_q)
      FETCH: begin
        // The reset state is FETCH, so gate IRWrite to keep every output low in reset.
        IRWrite = Enable & ~Reset;
        if (Enable) state_d = DECODE;
      end

      DECODE: begin
        if (is_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          // Illegal opcode retires as a 2-cycle NOP.
          PCWrite   = 1'b1;
          IllegalOp = 1'b1;
          state_d   = FETCH;
        end
      end

      EXEC: begin
        if (opcode_q == OP_RTYPE) begin
          ALUOp   = ALU_FUNCT;
          RegDst  = 1'b1;
          state_d = WB;
        end else if (is_itype(opcode_q)) begin
          ALUSrc  = 1'b1;
          ALUOp   = ALU_IMM;
          state_d = WB;
        end else if ((opcode_q == OP_LW) || (opcode_q == OP_SW)) begin
          ALUSrc  = 1'b1;
          ALUOp   = ALU_ADD;
          state_d = MEM;
        end else begin
          // BEQ: the datapath selects the target PC through the zero flag.
          ALUOp   = ALU_SUB;
          Branch  = 1'b1;
          PCWrite = 1'b1;
          state_d = FETCH;
        end
      end

      MEM: begin
        // Hold the address computation stable while the memory may stall.
        ALUSrc   = 1'b1;
        ALUOp    = ALU_ADD;
        MemRead  = (opcode_q == OP_LW);
        MemWrite = (opcode_q == OP_SW);
        if (MemReady) begin
          if (opcode_q == OP_LW) begin
            state_d = WB;
          end else begin
            PCWrite = 1'b1;
            state_d = FETCH;
          end
        end
      end

      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        // Hold EXEC's ALU controls so the write-back value stays stable.
        if (opcode_q == OP_RTYPE) begin
          ALUOp  = ALU_FUNCT;
          RegDst = 1'b1;
        end else if (is_itype(opcode_q)) begin
          ALUSrc = 1'b1;
          ALUOp  = ALU_IMM;
        end else begin
          MemToReg = 1'b1;
          ALUSrc   = 1'b1;
          ALUOp    = ALU_ADD;
        end
        state_d = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  // Every instruction, illegal NOPs included, pulses PCWrite exactly once.
  always_comb begin
    instr_count_d = instr_count_q;
    if (PCWrite) instr_count_d = CNT_W'(instr_count_q + CNT_W'(1));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) instr_count_q <= '0;
    else       instr_count_q <= instr_count_d;
  end

  assign InstrCount = instr_count_q;
`else
  assign InstrCount = CNT_W'(0);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares the full control vector against hand-derived values.
module tb_multicycle_control;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic [3:0]  opcode;
  logic        MemReady;
  logic        IRWrite, PCWrite, RegDst, Branch, MemRead, MemWrite;
  logic        RegWrite, MemToReg, ALUSrc, Busy, IllegalOp;
  logic [1:0]  ALUOp;
  logic [15:0] InstrCount;

  int n_checks = 0;
  int n_errors = 0;

  // Control vector bit masks: {IR,PC,RD,BR,MRD,MWR,RW,M2R,AS,ALUOp[1:0],BSY,ILL}
  localparam logic [12:0] C_NONE = 13'h0000;
  localparam logic [12:0] C_IR   = 13'h1000;
  localparam logic [12:0] C_PC   = 13'h0800;
  localparam logic [12:0] C_RD   = 13'h0400;
  localparam logic [12:0] C_BR   = 13'h0200;
  localparam logic [12:0] C_MRD  = 13'h0100;
  localparam logic [12:0] C_MWR  = 13'h0080;
  localparam logic [12:0] C_RW   = 13'h0040;
  localparam logic [12:0] C_M2R  = 13'h0020;
  localparam logic [12:0] C_AS   = 13'h0010;
  localparam logic [12:0] C_SUB  = 13'h0004;
  localparam logic [12:0] C_FN   = 13'h0008;
  localparam logic [12:0] C_IMM  = 13'h000C;
  localparam logic [12:0] C_BSY  = 13'h0002;
  localparam logic [12:0] C_ILL  = 13'h0001;

  logic [12:0] ctl;
  assign ctl = {IRWrite, PCWrite, RegDst, Branch, MemRead, MemWrite, RegWrite,
                MemToReg, ALUSrc, ALUOp, Busy, IllegalOp};

  multicycle_control dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .opcode     (opcode),
    .MemReady   (MemReady),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegDst     (RegDst),
    .Branch     (Branch),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemToReg   (MemToReg),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .Busy       (Busy),
    .IllegalOp  (IllegalOp),
    .InstrCount (InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge: drive inputs, check this cycle's
  // outputs, then advance to 1 time unit after the next rising edge.
  task automatic run_cycle(input string tag, input logic en, input logic [3:0] op,
                           input logic mr, input logic [12:0] exp);
    Enable   = en;
    opcode   = op;
    MemReady = mr;
    #2;
    check_eq(tag, 16'(ctl), 16'(exp));
    @(posedge Clock);
    #1;
  endtask

  logic [15:0] exp_count;

  initial begin
    Reset    = 1'b1;
    Enable   = 1'b1;
    opcode   = 4'b0000;
    MemReady = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    // Enable high during reset must not leak onto IRWrite.
    check_eq("reset_ctl", 16'(ctl), 16'(C_NONE));
    check_eq("reset_cnt", InstrCount, 16'h0000);
    Reset = 1'b0;

    // R-type; opcode input scrambled after DECODE to exercise the latch.
    run_cycle("r_fetch", 1'b1, 4'b0000, 1'b1, C_IR);
    run_cycle("r_dec",   1'b1, 4'b0000, 1'b1, C_BSY);
    run_cycle("r_exec",  1'b1, 4'b1111, 1'b1, C_RD | C_FN | C_BSY);
    run_cycle("r_wb",    1'b1, 4'b1111, 1'b1, C_PC | C_RW | C_RD | C_FN | C_BSY);

    // LW with three MEM stall cycles: 8 cycles total.
    run_cycle("lw_fetch", 1'b1, 4'b1000, 1'b1, C_IR);
    run_cycle("lw_dec",   1'b1, 4'b1000, 1'b1, C_BSY);
    run_cycle("lw_exec",  1'b1, 4'b1000, 1'b0, C_AS | C_BSY);
    for (int i = 0; i < 3; i++)
      run_cycle($sformatf("lw_stall%0d", i), 1'b0, 4'b1000, 1'b0, C_MRD | C_AS | C_BSY);
    run_cycle("lw_mem",  1'b0, 4'b1000, 1'b1, C_MRD | C_AS | C_BSY);
    run_cycle("lw_wb",   1'b0, 4'b1000, 1'b0, C_PC | C_RW | C_M2R | C_AS | C_BSY);

    // SW then BEQ.
    run_cycle("sw_fetch", 1'b1, 4'b1001, 1'b1, C_IR);
    run_cycle("sw_dec",   1'b1, 4'b1001, 1'b1, C_BSY);
    run_cycle("sw_exec",  1'b1, 4'b1001, 1'b1, C_AS | C_BSY);
    run_cycle("sw_mem",   1'b1, 4'b1001, 1'b1, C_MWR | C_PC | C_AS | C_BSY);
    run_cycle("beq_fetch", 1'b1, 4'b0100, 1'b1, C_IR);
    run_cycle("beq_dec",   1'b1, 4'b0100, 1'b1, C_BSY);
    run_cycle("beq_exec",  1'b1, 4'b0100, 1'b1, C_BR | C_SUB | C_PC | C_BSY);
    run_cycle("beq_done",  1'b0, 4'b0100, 1'b1, C_NONE);

    // Illegal opcodes: two-cycle NOP each.
    run_cycle("ill_fetch", 1'b1, 4'b1111, 1'b1, C_IR);
    run_cycle("ill_dec",   1'b1, 4'b1111, 1'b1, C_PC | C_ILL | C_BSY);
    run_cycle("ill2_fetch", 1'b1, 4'b0101, 1'b1, C_IR);
    run_cycle("ill2_dec",   1'b1, 4'b0101, 1'b1, C_PC | C_ILL | C_BSY);
    run_cycle("ill_done",  1'b0, 4'b0101, 1'b1, C_NONE);

    // Asynchronous reset in the middle of a LW MEM stall.
    run_cycle("rst_fetch", 1'b1, 4'b1000, 1'b0, C_IR);
    run_cycle("rst_dec",   1'b1, 4'b1000, 1'b0, C_BSY);
    run_cycle("rst_exec",  1'b0, 4'b1000, 1'b0, C_AS | C_BSY);
    run_cycle("rst_stall", 1'b0, 4'b1000, 1'b0, C_MRD | C_AS | C_BSY);
    #2;
    check_eq("rst_pre", 16'(ctl), 16'(C_MRD | C_AS | C_BSY));
    Reset = 1'b1;
    #1;
    check_eq("rst_async", 16'(ctl), 16'(C_NONE));
    check_eq("rst_cnt", InstrCount, 16'h0000);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Idle with Enable low, then three back-to-back ADDI; MemReady low is ignored.
    for (int i = 0; i < 5; i++)
      run_cycle($sformatf("idle%0d", i), 1'b0, 4'b0001, 1'b0, C_NONE);
    for (int k = 0; k < 3; k++) begin
      run_cycle($sformatf("addi%0d_fetch", k), 1'b1, 4'b0001, 1'b0, C_IR);
      run_cycle($sformatf("addi%0d_dec", k),   1'b1, 4'b0001, 1'b0, C_BSY);
      run_cycle($sformatf("addi%0d_exec", k),  1'b1, 4'b0001, 1'b0, C_AS | C_IMM | C_BSY);
      run_cycle($sformatf("addi%0d_wb", k),    1'b1, 4'b0001, 1'b0, C_PC | C_RW | C_AS | C_IMM | C_BSY);
    end
    run_cycle("addi_done", 1'b0, 4'b0001, 1'b0, C_NONE);
`ifdef CTRL_PERF_CNT_EN
    exp_count = 16'd3;
`else
    exp_count = 16'd0;
`endif
    check_eq("instr_count", InstrCount, exp_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the 16-bit CPU datapath. It replaces single-cycle decode with a Moore FSM that fetches, decodes, executes, accesses memory and writes back over several cycles. It drives every datapath control line plus PC/IR write enables, and stalls on a data-memory ready handshake. It sits between the CPU top level and the datapath; its input is the 4-bit opcode from instruction[15:12].

Parameters:
RESET_OPCODE, 4'b0000, value loaded into the internal opcode latch on reset.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high; forces FETCH.
Enable  input  1  run permission; sampled only in FETCH.
opcode  input  4  instruction[15:12] from the datapath; valid from DECODE onward.
MemReady  input  1  data memory has completed the current read/write.
IRWrite  output  1  capture the instruction word.
PCWrite  output  1  PC update strobe, one cycle per instruction.
RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc  output  1 each  datapath controls.
ALUOp  output  2  00 add, 01 sub (BEQ), 10 R-type funct, 11 I-type by opcode.
Busy  output  1  high whenever state != FETCH.
IllegalOp  output  1  one-cycle pulse on an undefined opcode.
InstrCount  output  16  retired-instruction count (optional feature).

Behaviour:
- Opcode map: 0000 R-type; 0001 ADDI; 0010 ANDI; 0011 ORI; 0100 BEQ; 1000 LW; 1001 SW; all others are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB. Encoding is free.
- Reset (asynchronous): state=FETCH, opcode latch=RESET_OPCODE, InstrCount=0. All outputs are 0 while Reset is high.
- Outputs are pure Moore decodes of state plus the latched opcode. Unlisted outputs are 0.
- FETCH:
  - IRWrite=Enable.
  - If Enable=1, go to DECODE; otherwise stay in FETCH.
- DECODE:
  - Latch opcode.
  - Legal opcode: go to EXEC.
  - Illegal opcode: PCWrite=1, IllegalOp=1, go to FETCH. This is a 2-cycle NOP.
- EXEC:
  - R-type: ALUOp=10, RegDst=1.
  - ADDI/ANDI/ORI: ALUSrc=1, ALUOp=11.
  - LW/SW: ALUSrc=1, ALUOp=00.
  - BEQ: ALUOp=01, Branch=1, PCWrite=1. The datapath selects the target via the zero flag. Go to FETCH; BEQ takes 3 cycles.
  - Next state: R/I go to WB; LW/SW go to MEM.
- MEM:
  - ALUSrc=1 and ALUOp=00 are held throughout.
  - LW: MemRead=1.
  - SW: MemWrite=1.
  - Stay in MEM while MemReady=0; MemRead/MemWrite stay asserted during the stall.
  - On MemReady=1: LW goes to WB; SW asserts PCWrite=1 in that cycle and goes to FETCH.
- WB:
  - RegWrite=1, PCWrite=1.
  - EXEC's ALUSrc/ALUOp/RegDst are held so the combinational ALU result stays stable.
  - LW: MemToReg=1, ALUSrc=1, ALUOp=00.
  - Go to FETCH.
- Latency with MemReady tied high and Enable=1: R/I 4 cycles, LW 5, SW 4, BEQ 3, illegal 2. Each MEM stall cycle adds 1.
- Invariants:
  - PCWrite is asserted exactly once per instruction.
  - MemRead and MemWrite are never asserted together.
  - RegWrite is only asserted in WB.
- Enable low mid-instruction has no effect; the current instruction completes and the FSM parks in FETCH.
- MemReady outside MEM is ignored.
- Reset asserted in any state, including a MEM stall, aborts immediately: no PCWrite, no RegWrite.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: InstrCount increments by 1 on each cycle with PCWrite=1, illegal NOPs included. It wraps 16'hFFFF to 0 and is cleared by Reset.
- Undefined: the port remains and is tied to 16'h0000; no counter flops are synthesised.

Test Plan:
1. Reset then Enable=1, opcode=0000, MemReady=1 -> states FETCH, DECODE, EXEC, WB. RegDst=1 and ALUOp=10 in EXEC and WB. RegWrite=1 and PCWrite=1 only in cycle 4. Busy low only in FETCH.
2. LW (1000) with MemReady low for 3 cycles in MEM -> MemRead=1 for 4 MEM cycles. WB follows with MemToReg=1 and RegWrite=1. Total 8 cycles, single PCWrite.
3. SW (1001) then BEQ (0100), MemReady=1 -> SW: MemWrite=1 and PCWrite=1 in the MEM cycle, RegWrite never 1. BEQ: Branch=1, ALUOp=01 and PCWrite=1 in EXEC, back in FETCH on cycle 4.
4. Opcode 1111 -> IllegalOp and PCWrite pulse in DECODE, 2 cycles total. No other controls assert.
5. Reset pulsed asynchronously mid-cycle during a LW MEM stall -> all outputs 0 immediately, state FETCH. With CTRL_PERF_CNT_EN, InstrCount=0.
6. Enable=0 in FETCH for 5 cycles, then 3 back-to-back ADDI (0001) with CTRL_PERF_CNT_EN -> no IRWrite while Enable=0, ALUSrc=1 and ALUOp=11, InstrCount reads 3.
